pipelined_cpu: RTL and testbench

- 5-stage in-order pipelined MIPS-subset core (IF, ID, EX, MEM, WB) with internal instruction memory, data memory and register file.
- Handles data hazards by forwarding, stalls one cycle on load-use, and resolves branches and jumps in ID, flushing one slot.
- Top-level compute block of the project; the bench preloads memories and the register file directly, then raises start_i.

---
 rtl/pipelined_cpu.sv | 258 +++++++++++++++++++++++++
 tb/tb_pipelined_cpu.sv | 350 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipelined_cpu.sv
// pipelined_cpu: 5-stage MIPS-subset core with forwarding, load-use stall, ID branches.
// Define PERF_COUNTER_EN to add stall_cnt_o / flush_cnt_o cycle counters.
module pipelined_cpu #(
    parameter int IMEM_WORDS = 256,
    parameter int DMEM_BYTES = 32
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic        start_i,
    output logic [31:0] pc_o,
    output logic        stall_o,
    output logic        flush_o
`ifdef PERF_COUNTER_EN
    ,
    output logic [31:0] stall_cnt_o,
    output logic [31:0] flush_cnt_o
`endif
);
    localparam int IAW = $clog2(IMEM_WORDS);
    localparam int DAW = $clog2(DMEM_BYTES);

    typedef enum logic [2:0] {
        ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_MUL
    } alu_op_e;

    typedef struct packed {
        logic [31:0] pc4;
        logic [31:0] instr;
    } if_id_t;

    typedef struct packed {
        alu_op_e     op;
        logic        use_imm;
        logic        mem_rd;
        logic        mem_wr;
        logic        reg_wr;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] imm;
    } id_ex_t;

    typedef struct packed {
        logic        mem_rd;
        logic        mem_wr;
        logic        reg_wr;
        logic [4:0]  rd;
        logic [31:0] alu;
        logic [31:0] sdata;
    } ex_mem_t;

    typedef struct packed {
        logic        reg_wr;
        logic [4:0]  rd;
        logic [31:0] data;
    } mem_wb_t;

    logic [31:0] imem [IMEM_WORDS];
    logic [7:0]  dmem [DMEM_BYTES];
    logic [31:0] rf   [32];

    logic [31:0] pc_q;
    if_id_t      if_id;
    id_ex_t      id_ex, dec;
    ex_mem_t     ex_mem, ex_next;
    mem_wb_t     mem_wb, wb_next;

    // ID stage fields and decode
    logic [5:0]  opc, funct;
    logic [4:0]  rs, rt, rd;
    logic [31:0] imm_ext, rs_val, rt_val, br_a, br_b, target;
    logic        is_r, is_addi, is_lw, is_sw, is_beq, is_j;
    logic        hazard, taken;
    alu_op_e     r_op;

    assign opc     = if_id.instr[31:26];
    assign funct   = if_id.instr[5:0];
    assign rs      = if_id.instr[25:21];
    assign rt      = if_id.instr[20:16];
    assign rd      = if_id.instr[15:11];
    assign imm_ext = {{16{if_id.instr[15]}}, if_id.instr[15:0]};

    always_comb begin
        r_op = ALU_ADD;
        is_r = 1'b1;
        unique case (funct)
            6'b100000: r_op = ALU_ADD;
            6'b100010: r_op = ALU_SUB;
            6'b100100: r_op = ALU_AND;
            6'b100101: r_op = ALU_OR;
            6'b011000: r_op = ALU_MUL;
            default:   is_r = 1'b0;
        endcase
        is_r = is_r && (opc == 6'b000000);
    end

    assign is_addi = (opc == 6'b001000);
    assign is_lw   = (opc == 6'b100011);
    assign is_sw   = (opc == 6'b101011);
    assign is_beq  = (opc == 6'b000100);
    assign is_j    = (opc == 6'b000010);

    // MEM-stage result, also forwarded to the ID branch comparator
    logic [DAW-3:0] wa;
    logic [31:0]    load_data, mem_res;
    assign wa        = ex_mem.alu[DAW-1:2];
    assign load_data = {dmem[{wa, 2'd3}], dmem[{wa, 2'd2}],
                        dmem[{wa, 2'd1}], dmem[{wa, 2'd0}]};
    assign mem_res   = ex_mem.mem_rd ? load_data : ex_mem.alu;

    always_comb begin
        rs_val = rf[rs];
        rt_val = rf[rt];
        if (mem_wb.reg_wr && mem_wb.rd == rs) rs_val = mem_wb.data;
        if (mem_wb.reg_wr && mem_wb.rd == rt) rt_val = mem_wb.data;
        if (rs == 5'd0) rs_val = '0;
        if (rt == 5'd0) rt_val = '0;
        br_a = rs_val;
        br_b = rt_val;
        if (ex_mem.reg_wr && ex_mem.rd != 5'd0 && ex_mem.rd == rs) br_a = mem_res;
        if (ex_mem.reg_wr && ex_mem.rd != 5'd0 && ex_mem.rd == rt) br_b = mem_res;
    end

    assign hazard = id_ex.mem_rd &&
                    (id_ex.rd == rs ||
                     (id_ex.rd == rt && (is_r || is_beq || is_sw)));
    assign taken  = is_j || (is_beq && br_a == br_b);
    assign target = is_j ? {if_id.pc4[31:28], if_id.instr[25:0], 2'b00}
                         : if_id.pc4 + {imm_ext[29:0], 2'b00};

    always_comb begin
        dec     = '0;
        dec.rs  = rs;
        dec.rt  = rt;
        dec.a   = rs_val;
        dec.b   = rt_val;
        dec.imm = imm_ext;
        unique case (1'b1)
            is_r: begin
                dec.op     = r_op;
                dec.reg_wr = 1'b1;
                dec.rd     = rd;
            end
            is_addi: begin
                dec.use_imm = 1'b1;
                dec.reg_wr  = 1'b1;
                dec.rd      = rt;
            end
            is_lw: begin
                dec.use_imm = 1'b1;
                dec.mem_rd  = 1'b1;
                dec.reg_wr  = 1'b1;
                dec.rd      = rt;
            end
            is_sw: begin
                dec.use_imm = 1'b1;
                dec.mem_wr  = 1'b1;
            end
            default: ;
        endcase
    end

    // EX stage with forwarding, EX/MEM ahead of MEM/WB
    logic [31:0] fa, fb, opb, alu_res;
    always_comb begin
        fa = id_ex.a;
        fb = id_ex.b;
        if (mem_wb.reg_wr && mem_wb.rd != 5'd0 && mem_wb.rd == id_ex.rs) fa = mem_wb.data;
        if (mem_wb.reg_wr && mem_wb.rd != 5'd0 && mem_wb.rd == id_ex.rt) fb = mem_wb.data;
        if (ex_mem.reg_wr && ex_mem.rd != 5'd0 && ex_mem.rd == id_ex.rs) fa = ex_mem.alu;
        if (ex_mem.reg_wr && ex_mem.rd != 5'd0 && ex_mem.rd == id_ex.rt) fb = ex_mem.alu;
        opb = id_ex.use_imm ? id_ex.imm : fb;
        unique case (id_ex.op)
            ALU_SUB: alu_res = fa - opb;
            ALU_AND: alu_res = fa & opb;
            ALU_OR:  alu_res = fa | opb;
            ALU_MUL: alu_res = fa * opb;
            default: alu_res = fa + opb;
        endcase
    end

    always_comb begin
        ex_next        = '0;
        ex_next.mem_rd = id_ex.mem_rd;
        ex_next.mem_wr = id_ex.mem_wr;
        ex_next.reg_wr = id_ex.reg_wr;
        ex_next.rd     = id_ex.rd;
        ex_next.alu    = alu_res;
        ex_next.sdata  = fb;
        wb_next        = '0;
        wb_next.reg_wr = ex_mem.reg_wr;
        wb_next.rd     = ex_mem.rd;
        wb_next.data   = mem_res;
    end

    logic [IAW-1:0] fetch_idx;
    if_id_t         fetch;
    assign fetch_idx   = pc_q[IAW+1:2];
    assign fetch.pc4   = pc_q + 32'd4;
    assign fetch.instr = imem[fetch_idx];

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            pc_q   <= '0;
            if_id  <= '0;
            id_ex  <= '0;
            ex_mem <= '0;
            mem_wb <= '0;
        end else if (start_i) begin
            ex_mem <= ex_next;
            mem_wb <= wb_next;
            if (hazard) begin
                id_ex <= '0;
            end else begin
                id_ex <= dec;
                if_id <= taken ? '0 : fetch;
                pc_q  <= taken ? target : fetch.pc4;
            end
        end
    end

    // Storage is not reset so preloaded contents survive reset
    always_ff @(posedge clk_i) begin
        if (start_i && mem_wb.reg_wr && mem_wb.rd != 5'd0)
            rf[mem_wb.rd] <= mem_wb.data;
    end

    always_ff @(posedge clk_i) begin
        if (start_i && ex_mem.mem_wr) begin
            dmem[{wa, 2'd0}] <= ex_mem.sdata[7:0];
            dmem[{wa, 2'd1}] <= ex_mem.sdata[15:8];
            dmem[{wa, 2'd2}] <= ex_mem.sdata[23:16];
            dmem[{wa, 2'd3}] <= ex_mem.sdata[31:24];
        end
    end

    assign pc_o    = pc_q;
    assign stall_o = start_i && hazard;
    assign flush_o = start_i && !hazard && taken;

`ifdef PERF_COUNTER_EN
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            stall_cnt_o <= '0;
            flush_cnt_o <= '0;
        end else begin
            if (stall_o) stall_cnt_o <= stall_cnt_o + 32'd1;
            if (flush_o) flush_cnt_o <= flush_cnt_o + 32'd1;
        end
    end
`endif

    logic unused_bits;
    assign unused_bits = ^{pc_q[31:IAW+2], pc_q[1:0], if_id.instr[10:6],
                           ex_mem.alu[31:DAW], ex_mem.alu[1:0]};
endmodule

// File: tb/tb_pipelined_cpu.sv
// tb_pipelined_cpu: directed programs preloaded into pipelined_cpu memories.
// Checks register/memory results, stall/flush pulses and PC control.
module tb_pipelined_cpu;
    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        start = 1'b0;
    logic [31:0] pc;
    logic        stall, flush;
`ifdef PERF_COUNTER_EN
    logic [31:0] stall_cnt, flush_cnt;
`endif
    int tests = 0;
    int fails = 0;
    int n_stall = 0;
    int n_flush = 0;

    always #5 clk = ~clk;

    pipelined_cpu dut (
        .clk_i      (clk),
        .rst_n_i    (rst_n),
        .start_i    (start),
        .pc_o       (pc),
        .stall_o    (stall),
        .flush_o    (flush)
`ifdef PERF_COUNTER_EN
        ,
        .stall_cnt_o(stall_cnt),
        .flush_cnt_o(flush_cnt)
`endif
    );

    function automatic logic [31:0] enc_r(input logic [5:0] f, input logic [4:0] s,
                                          input logic [4:0] t, input logic [4:0] d);
        return {6'd0, s, t, d, 5'd0, f};
    endfunction

    function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] s,
                                          input logic [4:0] t, input logic [15:0] imm);
        return {op, s, t, imm};
    endfunction

    function automatic logic [31:0] enc_j(input logic [25:0] a);
        return {6'b000010, a};
    endfunction

    localparam logic [5:0] ADDI = 6'b001000, LW = 6'b100011, SW = 6'b101011, BEQ = 6'b000100;
    localparam logic [5:0] F_ADD = 6'b100000, F_SUB = 6'b100010, F_AND = 6'b100100;
    localparam logic [5:0] F_OR = 6'b100101, F_MUL = 6'b011000;

    task automatic step();
        @(negedge clk);
        n_stall += int'(stall);
        n_flush += int'(flush);
    endtask

    task automatic init_mem();
        rst_n = 1'b0;
        start = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 256; i++) dut.imem[i] = '0;
        for (int i = 0; i < 32; i++) dut.dmem[i] = '0;
        for (int i = 0; i < 32; i++) dut.rf[i] = '0;
        n_stall = 0;
        n_flush = 0;
    endtask

    task automatic test_reset();
        #2 rst_n = 1'b0;
        #1;
        tests++;
        if (pc !== 32'd0) begin
            fails++;
            $display("FAIL reset_pc: got %0d expected 0", pc);
        end
        tests++;
        if (stall !== 1'b0 || flush !== 1'b0) begin
            fails++;
            $display("FAIL reset_flags: got stall=%0b flush=%0b expected 0 0", stall, flush);
        end
    endtask

    task automatic test_arith_forward();
        int          regs[5] = '{8, 9, 10, 11, 12};
        logic [31:0] expv[5] = '{32'd7, 32'd3, 32'd10, 32'd7, 32'd21};
        init_mem();
        dut.dmem[0] = 8'd7;
        dut.imem[0] = enc_i(LW, 5'd0, 5'd8, 16'd0);
        dut.imem[1] = enc_i(ADDI, 5'd0, 5'd9, 16'd3);
        dut.imem[2] = enc_r(F_ADD, 5'd8, 5'd9, 5'd10);
        dut.imem[3] = enc_r(F_SUB, 5'd10, 5'd9, 5'd11);
        dut.imem[4] = enc_r(F_MUL, 5'd8, 5'd9, 5'd12);
        rst_n = 1'b1;
        start = 1'b1;
        repeat (14) step();
        start = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tests++;
            if (dut.rf[regs[i]] !== expv[i]) begin
                fails++;
                $display("FAIL arith_r%0d: got %0d expected %0d", regs[i], dut.rf[regs[i]], expv[i]);
            end
        end
        tests++;
        if (n_stall != 0) begin
            fails++;
            $display("FAIL arith_stalls: got %0d expected 0", n_stall);
        end
    endtask

    task automatic test_logic_ops();
        init_mem();
        dut.imem[0] = enc_i(ADDI, 5'd0, 5'd8, 16'd12);
        dut.imem[1] = enc_i(ADDI, 5'd0, 5'd9, 16'd10);
        dut.imem[2] = enc_r(F_AND, 5'd8, 5'd9, 5'd10);
        dut.imem[3] = enc_r(F_OR, 5'd8, 5'd9, 5'd11);
        dut.imem[4] = enc_i(ADDI, 5'd0, 5'd0, 16'd5);
        rst_n = 1'b1;
        start = 1'b1;
        repeat (12) step();
        start = 1'b0;
        tests++;
        if (dut.rf[10] !== 32'd8 || dut.rf[11] !== 32'd14) begin
            fails++;
            $display("FAIL logic_ops: got and=%0d or=%0d expected 8 14", dut.rf[10], dut.rf[11]);
        end
        tests++;
        if (dut.rf[0] !== 32'd0) begin
            fails++;
            $display("FAIL r0_write: got %0d expected 0", dut.rf[0]);
        end
    endtask

    task automatic test_load_use();
        init_mem();
        dut.dmem[0] = 8'd7;
        dut.imem[0] = enc_i(LW, 5'd0, 5'd8, 16'd0);
        dut.imem[1] = enc_r(F_ADD, 5'd8, 5'd8, 5'd9);
        rst_n = 1'b1;
        start = 1'b1;
        step();
        step();
        tests++;
        if (stall !== 1'b1 || pc !== 32'd8) begin
            fails++;
            $display("FAIL load_use_stall: got stall=%0b pc=%0d expected 1 8", stall, pc);
        end
        step();
        tests++;
        if (stall !== 1'b0 || pc !== 32'd8) begin
            fails++;
            $display("FAIL load_use_hold: got stall=%0b pc=%0d expected 0 8", stall, pc);
        end
        repeat (9) step();
        start = 1'b0;
        tests++;
        if (dut.rf[9] !== 32'd14) begin
            fails++;
            $display("FAIL load_use_r9: got %0d expected 14", dut.rf[9]);
        end
        tests++;
        if (n_stall != 1) begin
            fails++;
            $display("FAIL load_use_count: got %0d expected 1", n_stall);
        end
`ifdef PERF_COUNTER_EN
        @(negedge clk);
        tests++;
        if (stall_cnt !== 32'd1 || flush_cnt !== 32'd0) begin
            fails++;
            $display("FAIL load_use_perf: got %0d %0d expected 1 0", stall_cnt, flush_cnt);
        end
`endif
    endtask

    task automatic test_branch_taken();
        init_mem();
        dut.imem[0] = enc_i(ADDI, 5'd0, 5'd8, 16'd1);
        dut.imem[1] = enc_i(BEQ, 5'd8, 5'd8, 16'd1);
        dut.imem[2] = enc_i(ADDI, 5'd0, 5'd9, 16'd5);
        dut.imem[3] = enc_i(ADDI, 5'd0, 5'd10, 16'd6);
        rst_n = 1'b1;
        start = 1'b1;
        step();
        step();
        tests++;
        if (flush !== 1'b1 || pc !== 32'd8) begin
            fails++;
            $display("FAIL beq_flush: got flush=%0b pc=%0d expected 1 8", flush, pc);
        end
        step();
        tests++;
        if (pc !== 32'd12) begin
            fails++;
            $display("FAIL beq_target: got %0d expected 12", pc);
        end
        repeat (9) step();
        start = 1'b0;
        tests++;
        if (dut.rf[9] !== 32'd0 || dut.rf[10] !== 32'd6) begin
            fails++;
            $display("FAIL beq_regs: got r9=%0d r10=%0d expected 0 6", dut.rf[9], dut.rf[10]);
        end
        tests++;
        if (n_flush != 1) begin
            fails++;
            $display("FAIL beq_flush_count: got %0d expected 1", n_flush);
        end
    endtask

    task automatic test_jump_store();
        logic [31:0] word;
        init_mem();
        dut.imem[0] = enc_j(26'd3);
        dut.imem[1] = enc_i(ADDI, 5'd0, 5'd9, 16'd9);
        dut.imem[3] = enc_i(ADDI, 5'd0, 5'd8, 16'd42);
        dut.imem[4] = enc_i(SW, 5'd0, 5'd8, 16'd4);
        rst_n = 1'b1;
        start = 1'b1;
        step();
        tests++;
        if (flush !== 1'b1 || pc !== 32'd4) begin
            fails++;
            $display("FAIL j_flush: got flush=%0b pc=%0d expected 1 4", flush, pc);
        end
        step();
        tests++;
        if (pc !== 32'd12) begin
            fails++;
            $display("FAIL j_target: got %0d expected 12", pc);
        end
        repeat (10) step();
        start = 1'b0;
        word = {dut.dmem[7], dut.dmem[6], dut.dmem[5], dut.dmem[4]};
        tests++;
        if (word !== 32'd42 || dut.rf[9] !== 32'd0) begin
            fails++;
            $display("FAIL j_store: got mem4=%0d r9=%0d expected 42 0", word, dut.rf[9]);
        end
        tests++;
        if (n_flush != 1) begin
            fails++;
            $display("FAIL j_flush_count: got %0d expected 1", n_flush);
        end
    endtask

    task automatic test_factorial();
        logic [31:0] word;
        init_mem();
        dut.dmem[0] = 8'd7;
        dut.imem[0] = enc_i(LW, 5'd0, 5'd8, 16'd0);
        dut.imem[1] = enc_i(ADDI, 5'd0, 5'd9, 16'd1);
        dut.imem[2] = enc_i(BEQ, 5'd8, 5'd0, 16'd3);
        dut.imem[3] = enc_r(F_MUL, 5'd9, 5'd8, 5'd9);
        dut.imem[4] = enc_i(ADDI, 5'd8, 5'd8, 16'hFFFF);
        dut.imem[5] = enc_j(26'd2);
        dut.imem[6] = enc_i(SW, 5'd0, 5'd9, 16'd4);
        rst_n = 1'b1;
        start = 1'b1;
        repeat (60) step();
        start = 1'b0;
        word = {dut.dmem[7], dut.dmem[6], dut.dmem[5], dut.dmem[4]};
        tests++;
        if (word !== 32'd5040) begin
            fails++;
            $display("FAIL fact_result: got %0d expected 5040", word);
        end
        tests++;
        if (n_stall != 0 || n_flush != 8) begin
            fails++;
            $display("FAIL fact_counts: got stall=%0d flush=%0d expected 0 8", n_stall, n_flush);
        end
`ifdef PERF_COUNTER_EN
        @(negedge clk);
        tests++;
        if (stall_cnt !== 32'd0 || flush_cnt !== 32'd8) begin
            fails++;
            $display("FAIL fact_perf: got %0d %0d expected 0 8", stall_cnt, flush_cnt);
        end
`endif
    endtask

    task automatic test_control();
        init_mem();
        dut.imem[0] = enc_i(ADDI, 5'd0, 5'd8, 16'd1);
        dut.imem[1] = enc_i(ADDI, 5'd0, 5'd9, 16'd2);
        dut.imem[2] = enc_i(ADDI, 5'd0, 5'd10, 16'd3);
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            tests++;
            if (pc !== 32'd0) begin
                fails++;
                $display("FAIL idle_pc_%0d: got %0d expected 0", i, pc);
            end
        end
        start = 1'b1;
        step();
        step();
        start = 1'b0;
        repeat (3) step();
        tests++;
        if (pc !== 32'd8) begin
            fails++;
            $display("FAIL pause_pc: got %0d expected 8", pc);
        end
        start = 1'b1;
        step();
        rst_n = 1'b0;
        #1;
        tests++;
        if (pc !== 32'd0 || stall !== 1'b0 || flush !== 1'b0) begin
            fails++;
            $display("FAIL midrun_reset: got pc=%0d stall=%0b flush=%0b expected 0 0 0", pc, stall, flush);
        end
        repeat (4) step();
        tests++;
        if (dut.rf[8] !== 32'd0) begin
            fails++;
            $display("FAIL squash_r8: got %0d expected 0", dut.rf[8]);
        end
        rst_n = 1'b1;
        repeat (10) step();
        start = 1'b0;
        tests++;
        if (pc !== 32'd40) begin
            fails++;
            $display("FAIL restart_pc: got %0d expected 40", pc);
        end
        tests++;
        if (dut.rf[8] !== 32'd1 || dut.rf[9] !== 32'd2 || dut.rf[10] !== 32'd3) begin
            fails++;
            $display("FAIL restart_regs: got %0d %0d %0d expected 1 2 3",
                     dut.rf[8], dut.rf[9], dut.rf[10]);
        end
    endtask

    initial begin
        test_reset();
        test_arith_forward();
        test_logic_ops();
        test_load_use();
        test_branch_taken();
        test_jump_store();
        test_factorial();
        test_control();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
